process_launcher: RTL and testbench

PROCESS_LAUNCHER -- requirements
Module: process_launcher

---
 rtl/process_launcher.sv | 109 ++++++++++
 tb/tb_process_launcher.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/process_launcher.sv
// Arms, delays and then starts NUM_CORES cores, waiting until every core has reported done.
// Optional run watchdog: define PROCESS_LAUNCHER_TIMEOUT_EN to enable the TIMEOUT exit.
module process_launcher #(
  parameter int NUM_CORES      = 3,
  parameter int START_DELAY    = 10,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic                 fast_clock,
  input  logic                 reset_n,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 start_process,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DELAY   = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  state_t               st;
  state_t               st_nx;
  logic [DW-1:0]        dly_cnt;
  logic [NUM_CORES-1:0] core_latch;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 all_done;
  logic                 tmo_hit;
  logic                 launch;

  assign cnt_inc  = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
  assign all_done = &(core_latch | core_done);
  assign launch   = (st == S_IDLE || st == S_DONE || st == S_TIMEOUT) && !abort && arm;
  assign state    = st;

`ifdef PROCESS_LAUNCHER_TIMEOUT_EN
  // Compared against the post-increment count so TIMEOUT lands on the edge the limit is reached.
  assign tmo_hit = (32'(cnt_inc) == 32'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    st_nx = st;
    unique case (st)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (abort)    st_nx = S_IDLE;
        else if (arm) st_nx = (START_DELAY == 0) ? S_RUN : S_DELAY;
      end
      S_DELAY: begin
        if (abort)                    st_nx = S_IDLE;
        else if (dly_cnt == DLY_LAST) st_nx = S_RUN;
      end
      S_RUN: begin
        if (abort)         st_nx = S_IDLE;
        else if (all_done) st_nx = S_DONE;
        else if (tmo_hit)  st_nx = S_TIMEOUT;
      end
      default: st_nx = S_IDLE;
    endcase
  end

  // Flags are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge fast_clock or negedge reset_n) begin
    if (!reset_n) begin
      st            <= S_IDLE;
      start_process <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef PROCESS_LAUNCHER_TIMEOUT_EN
      timeout       <= 1'b0;
`endif
      cycle_count   <= '0;
      core_latch    <= '0;
      dly_cnt       <= '0;
    end else begin
      st            <= st_nx;
      start_process <= (st_nx == S_RUN);
      busy          <= (st_nx == S_DELAY) || (st_nx == S_RUN);
      done          <= (st_nx == S_DONE);
`ifdef PROCESS_LAUNCHER_TIMEOUT_EN
      timeout       <= (st_nx == S_TIMEOUT);
`endif
      if (launch) begin
        cycle_count <= '0;
        core_latch  <= '0;
        dly_cnt     <= '0;
      end else if (st == S_DELAY) begin
        dly_cnt <= dly_cnt + DW'(1);
      end else if (st == S_RUN && !abort) begin
        cycle_count <= cnt_inc;
        core_latch  <= core_latch | core_done;
      end
    end
  end

endmodule

// File: tb/tb_process_launcher.sv
// Bench for process_launcher: three configurations share stimulus and are checked against an
// event-time reference model (launch edge, run start edge, end edge) every cycle.
module tb_process_launcher;

  logic fast_clock = 1'b0;
  always #5 fast_clock = ~fast_clock;

  logic       reset_n;
  logic       arm;
  logic       abort;
  logic [2:0] core_done;

  logic [2:0]  st_o [3];
  logic        sp_o [3];
  logic        bz_o [3];
  logic        dn_o [3];
  logic        to_o [3];
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [7:0]  cnt_c;

  process_launcher #(.NUM_CORES(3), .START_DELAY(10), .TIMEOUT_CYCLES(1000), .CNT_W(16)) u_a (
    .fast_clock(fast_clock), .reset_n(reset_n), .arm(arm), .abort(abort), .core_done(core_done),
    .start_process(sp_o[0]), .busy(bz_o[0]), .done(dn_o[0]), .timeout(to_o[0]),
    .cycle_count(cnt_a), .state(st_o[0]));

  process_launcher #(.NUM_CORES(3), .START_DELAY(0), .TIMEOUT_CYCLES(1000), .CNT_W(4)) u_b (
    .fast_clock(fast_clock), .reset_n(reset_n), .arm(arm), .abort(abort), .core_done(core_done),
    .start_process(sp_o[1]), .busy(bz_o[1]), .done(dn_o[1]), .timeout(to_o[1]),
    .cycle_count(cnt_b), .state(st_o[1]));

  process_launcher #(.NUM_CORES(3), .START_DELAY(2), .TIMEOUT_CYCLES(20), .CNT_W(8)) u_c (
    .fast_clock(fast_clock), .reset_n(reset_n), .arm(arm), .abort(abort), .core_done(core_done),
    .start_process(sp_o[2]), .busy(bz_o[2]), .done(dn_o[2]), .timeout(to_o[2]),
    .cycle_count(cnt_c), .state(st_o[2]));

`ifdef PROCESS_LAUNCHER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  int     p_sd  [3] = '{10, 0, 2};
  int     p_to  [3] = '{1000, 1000, 20};
  longint p_max [3] = '{65535, 15, 255};

  // Reference model: a run is described by the edges at which it started/ended, not by a state register.
  bit         act   [3];
  int         run_e [3];
  int         end_e [3];
  int         end_k [3];
  longint     held  [3];
  logic [2:0] seen  [3];

  int e_n    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  function automatic int view(int d, int e);
    if (!act[d]) return 0;
    if (end_e[d] >= 0 && e >= end_e[d]) return end_k[d];
    if (e < run_e[d]) return 1;
    return 2;
  endfunction

  function automatic longint cnt_at(int d, int e);
    longint span;
    if (!act[d]) return held[d];
    if (e < run_e[d]) return 0;
    span = longint'((end_e[d] >= 0 && end_e[d] < e) ? end_e[d] : e) - longint'(run_e[d]);
    return (span > p_max[d]) ? p_max[d] : span;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      act[d]  = 1'b0;
      held[d] = 0;
    end
  endtask

  task automatic model_edge(int e);
    for (int d = 0; d < 3; d++) begin
      int prev;
      prev = view(d, e - 1);
      if (!reset_n) begin
        act[d]  = 1'b0;
        held[d] = 0;
      end else if (abort) begin
        if (prev != 0) begin
          held[d] = cnt_at(d, e - 1);
          act[d]  = 1'b0;
        end
      end else if (arm && (prev == 0 || prev >= 3)) begin
        act[d]   = 1'b1;
        run_e[d] = e + p_sd[d];
        end_e[d] = -1;
        end_k[d] = 0;
        seen[d]  = 3'b000;
      end else if (prev == 2) begin
        seen[d] = seen[d] | core_done;
        if (seen[d] == 3'b111) begin
          end_e[d] = e;
          end_k[d] = 3;
        end else if (TMO_EN && cnt_at(d, e) == longint'(p_to[d])) begin
          end_e[d] = e;
          end_k[d] = 4;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] cnt_obs(int d);
    case (d)
      0:       return 32'(cnt_a);
      1:       return 32'(cnt_b);
      default: return 32'(cnt_c);
    endcase
  endfunction

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      int v;
      v = view(d, e_n);
      chk($sformatf("dut%0d.state", d),         32'(st_o[d]), 32'(v));
      chk($sformatf("dut%0d.start_process", d), 32'(sp_o[d]), 32'(v == 2));
      chk($sformatf("dut%0d.busy", d),          32'(bz_o[d]), 32'(v == 1 || v == 2));
      chk($sformatf("dut%0d.done", d),          32'(dn_o[d]), 32'(v == 3));
      chk($sformatf("dut%0d.timeout", d),       32'(to_o[d]), 32'(v == 4));
      chk($sformatf("dut%0d.cycle_count", d),   cnt_obs(d),   32'(cnt_at(d, e_n)));
    end
  endtask

  task automatic tick();
    @(posedge fast_clock);
    e_n++;
    model_edge(e_n);
    #1;
    check_all();
  endtask

  initial begin
    reset_n = 1'b1; arm = 1'b0; abort = 1'b0; core_done = 3'b000;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    check_all();
    chk("A.reset_state", 32'(st_o[0]), 32'd0);
    chk("A.reset_count", 32'(cnt_a), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic run: arm, arm-while-busy ignored, start after 10 cycles, all cores at once.
    arm = 1'b1; tick(); arm = 1'b0;
    chk("A.arm_to_delay", 32'(st_o[0]), 32'd1);
    chk("B.arm_to_run", 32'(st_o[1]), 32'd2);
    repeat (2) tick();
    arm = 1'b1; tick(); arm = 1'b0;
    chk("A.arm_busy_ignored", 32'(st_o[0]), 32'd1);
    repeat (5) tick();
    tick();
    chk("A.start_low_k9", 32'(sp_o[0]), 32'd0);
    tick();
    chk("A.start_high_k10", 32'(sp_o[0]), 32'd1);
    repeat (24) tick();
    core_done = 3'b111; tick(); core_done = 3'b000;
    chk("A.done_k35", 32'(dn_o[0]), 32'd1);
    chk("A.start_off_k35", 32'(sp_o[0]), 32'd0);
    chk("A.count_k35", 32'(cnt_a), 32'd25);

    // Staggered completion from DONE; a DELAY-phase pulse must be discarded.
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (2) tick();
    core_done = 3'b100; tick(); core_done = 3'b000;
    repeat (11) tick();
    core_done = 3'b001; tick(); core_done = 3'b000;
    repeat (9) tick();
    core_done = 3'b010; tick(); core_done = 3'b000;
    repeat (19) tick();
    chk("A.stagger_still_run", 32'(st_o[0]), 32'd2);
    core_done = 3'b100; tick();
    chk("A.stagger_done", 32'(st_o[0]), 32'd3);
    chk("A.stagger_count", 32'(cnt_a), 32'd35);
    repeat (2) tick();
    core_done = 3'b000;

    // Abort during DELAY.
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (3) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("A.abort_delay_state", 32'(st_o[0]), 32'd0);
    chk("A.abort_delay_busy", 32'(bz_o[0]), 32'd0);
    repeat (12) tick();
    chk("A.abort_delay_nostart", 32'(sp_o[0]), 32'd0);

    // Abort during RUN, together with arm: abort wins and the count is held.
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (14) tick();
    abort = 1'b1; arm = 1'b1; tick(); abort = 1'b0; arm = 1'b0;
    chk("A.abort_run_state", 32'(st_o[0]), 32'd0);
    chk("A.abort_run_start", 32'(sp_o[0]), 32'd0);
    chk("A.abort_run_count", 32'(cnt_a), 32'd4);
    tick();
    chk("A.abort_run_idle", 32'(st_o[0]), 32'd0);

    // Watchdog: no completion for a long run.
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (1009) tick();
    chk("A.wd_run_999", 32'(st_o[0]), 32'd2);
    tick();
`ifdef PROCESS_LAUNCHER_TIMEOUT_EN
    chk("A.wd_timeout", 32'(to_o[0]), 32'd1);
    chk("A.wd_state", 32'(st_o[0]), 32'd4);
    chk("A.wd_count", 32'(cnt_a), 32'd1000);
`else
    repeat (1000) tick();
    chk("A.nowd_still_run", 32'(st_o[0]), 32'd2);
    chk("A.nowd_count", 32'(cnt_a), 32'd2000);
`endif
    abort = 1'b1; tick(); abort = 1'b0;

    // Last core arrives on the same edge the watchdog limit is reached.
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (14) tick();
    core_done = 3'b001; tick();
    core_done = 3'b010; tick();
    core_done = 3'b000;
    repeat (993) tick();
    core_done = 3'b100; tick(); core_done = 3'b000;
    chk("A.coinc_done", 32'(dn_o[0]), 32'd1);
    chk("A.coinc_timeout", 32'(to_o[0]), 32'd0);
    chk("A.coinc_count", 32'(cnt_a), 32'd1000);
    abort = 1'b1; tick(); abort = 1'b0;

    // Saturation of the 4-bit counter, then asynchronous reset mid-RUN.
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (20) tick();
    chk("B.sat_count", 32'(cnt_b), 32'd15);
    chk("B.sat_state", 32'(st_o[1]), 32'd2);
    chk("A.pre_reset_count", 32'(cnt_a), 32'd10);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("A.async_state", 32'(st_o[0]), 32'd0);
    chk("A.async_start", 32'(sp_o[0]), 32'd0);
    chk("A.async_busy", 32'(bz_o[0]), 32'd0);
    chk("A.async_count", 32'(cnt_a), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("A.post_reset_idle", 32'(st_o[0]), 32'd0);

    // Randomized traffic against the model.
    repeat (1500) begin
      arm       = ($urandom_range(7) == 0);
      abort     = ($urandom_range(39) == 0);
      core_done = {($urandom_range(5) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0)};
      tick();
    end
    arm = 1'b0; abort = 1'b0; core_done = 3'b000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
